ccff_chain_loader: RTL and testbench

- Upstream feeder for a configuration/scan chain built from scan flip-flops with SE/SI pins, connected Q-to-SI.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain head (SI).
- Asserts SE for exactly CHAIN_LEN clock cycles, then signals completion.
- Sits between the bitstream source and the fabric's configuration flip-flop chain.

---
 rtl/ccff_chain_loader.sv | 126 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: feeds configuration words LSB-first into a scan flip-flop chain (SE/SI).
// Optional parity check of the shifted bitstream is enabled by defining CCFF_LOADER_PARITY_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              SI,
    output logic              SE,
    output logic              busy,
    output logic              done
`ifdef CCFF_LOADER_PARITY_EN
    ,
    input  logic              exp_parity,
    output logic              parity_err
`endif
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WB_W-1:0]  WB_LOAD  = WB_W'(WORD_W);
    localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   wbit_q, wbit_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              se_q, se_d;
    logic              si_q, si_d;

    // State, counters, shift register and the registered SE/SI pins
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            wbit_q    <= '0;
            sreg_q    <= '0;
            se_q      <= 1'b0;
            si_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
            sreg_q    <= sreg_d;
            se_q      <= se_d;
            si_q      <= si_d;
        end
    end

    // Next state; SE/SI are precomputed so they are high exactly during SHIFT cycles
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        sreg_d    = sreg_q;
        se_d      = 1'b0;
        si_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = CNT_LOAD;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    state_d = SHIFT;
                    wbit_d  = WB_LOAD;
                    sreg_d  = word_in >> 1;
                    se_d    = 1'b1;
                    si_d    = word_in[0];
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q - 1'b1;
                wbit_d    = wbit_q - 1'b1;
                sreg_d    = sreg_q >> 1;
                if (bit_cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else if (wbit_q == WB_ONE) begin
                    state_d = FETCH;
                end else begin
                    se_d = 1'b1;
                    si_d = sreg_q[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_ready = (state_q == FETCH);
    assign SE         = se_q;
    assign SI         = si_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef CCFF_LOADER_PARITY_EN
    logic acc_q, exp_q, err_q;

    // Parity of every bit driven while SE is high, compared on entry to DONE
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            acc_q <= 1'b0;
            exp_q <= 1'b0;
            err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            acc_q <= 1'b0;
            exp_q <= exp_parity;
            err_q <= 1'b0;
        end else begin
            if (se_q) acc_q <= acc_q ^ si_q;
            if (state_q == SHIFT && state_d == DONE) err_q <= (acc_q ^ si_q) != exp_q;
        end
    end

    assign parity_err = err_q;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed and randomized loads checked against a model scan chain.
module tb_ccff_chain_loader;
    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       word_valid = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] word_in = '0;
    logic       st64, st10;
    logic       rdy64, rdy10, si64, si10, se64, se10, busy64, busy10, done64, done10;
`ifdef CCFF_LOADER_PARITY_EN
    logic       exp_parity = 1'b0;
    logic       perr64, perr10, perr_s, perr_done;
`endif
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          se_n, hs_n, dn_n, busy_n, fetch_se;
    logic        rdy_s = 1'b0;
    logic [63:0] chain = '0;
    logic [63:0] prev;
    logic [7:0]  words [8];

    assign st64 = start & ~sel;
    assign st10 = start & sel;

    always #5 CK = ~CK;

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) d64 (
        .CK(CK), .RST(RST), .start(st64), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy64), .SI(si64), .SE(se64), .busy(busy64), .done(done64)
`ifdef CCFF_LOADER_PARITY_EN
        , .exp_parity(exp_parity), .parity_err(perr64)
`endif
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) d10 (
        .CK(CK), .RST(RST), .start(st10), .word_in(word_in), .word_valid(word_valid),
        .word_ready(rdy10), .SI(si10), .SE(se10), .busy(busy10), .done(done10)
`ifdef CCFF_LOADER_PARITY_EN
        , .exp_parity(exp_parity), .parity_err(perr10)
`endif
    );

    function automatic logic [63:0] len_mask(input int len);
        return (len >= 64) ? '1 : (64'd1 << len) - 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One clock: commit the handshake the coming edge will see, then sample the selected DUT mid-cycle
    task automatic tick();
        int len;
        len = sel ? 10 : 64;
        if (rdy_s && word_valid) hs_n++;
        @(negedge CK);
        cyc++;
        rdy_s = sel ? rdy10 : rdy64;
        if (sel ? se10 : se64) begin
            se_n++;
            if (rdy_s) fetch_se++;
            chain = ((chain & len_mask(len)) >> 1) | (64'(sel ? si10 : si64) << (len - 1));
        end
        if (sel ? busy10 : busy64) busy_n++;
        if (sel ? done10 : done64) dn_n++;
`ifdef CCFF_LOADER_PARITY_EN
        perr_s = sel ? perr10 : perr64;
`endif
    endtask

    // Full load of ceil(len/8) words from words[], optional FETCH stall and start pulse during SHIFT
    task automatic load(input int len, input int stall, input bit poke);
        int nw, t0, t1, n;
        logic [63:0] exp_chain;
        nw = (len + 7) / 8;
        exp_chain = '0;
        for (int k = 0; k < nw; k++) exp_chain |= 64'(words[k]) << (8 * k);
        exp_chain &= len_mask(len);
        se_n = 0; hs_n = 0; dn_n = 0; busy_n = 0; fetch_se = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
`ifdef CCFF_LOADER_PARITY_EN
        chk("parity_clear_on_start", 64'(perr_s), 64'd0);
`endif
        for (int k = 0; k < nw; k++) begin
            word_in = words[k];
            if (k > 0 && stall > 0) begin
                word_valid = 1'b0;
                n = 0;
                while (!rdy_s && n < 100) begin tick(); n++; end
                repeat (stall) tick();
            end
            word_valid = 1'b1;
            n = 0;
            while (hs_n <= k && n < 100) begin tick(); n++; end
            chk("handshake_reached", 64'(hs_n), 64'(k + 1));
            if (poke && k == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        n = 0;
        while (dn_n == 0 && n < 200) begin tick(); n++; end
        t1 = cyc;
`ifdef CCFF_LOADER_PARITY_EN
        perr_done = perr_s;
`endif
        tick();
        tick();
        word_valid = 1'b0;
        chk("chain", chain & len_mask(len), exp_chain);
        chk("se_cycles", 64'(se_n), 64'(len));
        chk("handshakes", 64'(hs_n), 64'(nw));
        chk("done_pulses", 64'(dn_n), 64'd1);
        chk("busy_span", 64'(busy_n), 64'(t1 - t0 + 1));
        chk("se_in_fetch", 64'(fetch_se), 64'd0);
        chk("busy_after", 64'(sel ? busy10 : busy64), 64'd0);
`ifdef CCFF_LOADER_PARITY_EN
        chk("parity_at_done", 64'(perr_done), 64'((^exp_chain) ^ exp_parity));
        chk("parity_held", 64'(perr_s), 64'((^exp_chain) ^ exp_parity));
`endif
    endtask

    initial begin
        int n;
        @(negedge CK);
        chk("reset_SE", 64'(se64), 64'd0);
        chk("reset_SI", 64'(si64), 64'd0);
        chk("reset_ready", 64'(rdy64), 64'd0);
        chk("reset_busy", 64'(busy64), 64'd0);
        chk("reset_done", 64'(done64), 64'd0);
        RST = 1'b0;
        tick();

        // Reset in the 20th SE cycle of a load
        for (int k = 0; k < 8; k++) words[k] = 8'(k + 1);
        sel = 1'b0;
        se_n = 0; hs_n = 0; dn_n = 0; busy_n = 0; fetch_se = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        word_valid = 1'b1;
        n = 0;
        while (se_n < 20 && n < 300) begin
            word_in = words[hs_n > 7 ? 7 : hs_n];
            tick();
            n++;
        end
        chk("pre_rst_handshakes", 64'(hs_n), 64'd3);
        chk("pre_rst_SE", 64'(se64), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("rst_async_SE", 64'(se64), 64'd0);
        chk("rst_async_busy", 64'(busy64), 64'd0);
        chk("rst_async_ready", 64'(rdy64), 64'd0);
        word_valid = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        load(64, 0, 1'b0);
        chk("reload_chain", chain, 64'h0807060504030201);

        // Partial last word
        sel = 1'b1;
        words[0] = 8'hA5;
        words[1] = 8'hFF;
        load(10, 0, 1'b0);
        chk("partial_chain", chain & len_mask(10), 64'h3A5);

        // Source stalls give the same result as an unstalled load
        sel = 1'b0;
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        load(64, 0, 1'b0);
        prev = chain;
        load(64, 5, 1'b0);
        chk("stall_same_chain", chain, prev);

        // Start pulsed while busy
        load(64, 0, 1'b1);

`ifdef CCFF_LOADER_PARITY_EN
        for (int k = 0; k < 8; k++) words[k] = 8'h01;
        exp_parity = 1'b0;
        load(64, 0, 1'b0);
        exp_parity = 1'b1;
        load(64, 0, 1'b0);
        exp_parity = 1'b0;
        load(64, 0, 1'b0);
`endif

        // Randomized loads on both chain lengths
        for (int r = 0; r < 8; r++) begin
            sel = r[0];
            for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
`ifdef CCFF_LOADER_PARITY_EN
            exp_parity = 1'($urandom_range(0, 1));
`endif
            load(sel ? 10 : 64, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
